axi_rd_id_arbiter: RTL



---
 rtl/axi_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 29 ++
 rtl/axi_rd_id_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/axi_pkg.sv
// Shared AXI4 constants and the AR request payload type.
package axi_pkg;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B     = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;
  localparam int         AXI_ID_W        = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } ar_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_arbiter #(
  parameter  int N  = 2,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);
  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (en && !found && req[j]) begin
        gnt[j] = 1'b1;
        idx    = PW'(j);
        found  = 1'b1;
      end
    end
  end
endmodule

// File: rtl/axi_rd_id_arbiter.sv
// Shares one AXI4 read master between N_REQ requesters, one ARID each;
// round-robin AR issue, per-requester outstanding cap, R steering by RID.
module axi_rd_id_arbiter
  import axi_pkg::*;
#(
  parameter int N_REQ           = 2,
  parameter int ID_W            = AXI_ID_W,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*32-1:0] req_addr,
  input  logic [N_REQ*8-1:0]  req_len,
  output logic [N_REQ-1:0]    rsp_valid,
  input  logic [N_REQ-1:0]    rsp_ready,
  output logic [31:0]         rsp_data,
  output logic [1:0]          rsp_resp,
  output logic                rsp_last,
  output logic [31:0]         M_AXI_ARADDR,
  output logic                M_AXI_ARVALID,
  input  logic                M_AXI_ARREADY,
  output logic [ID_W-1:0]     M_AXI_ARID,
  output logic [7:0]          M_AXI_ARLEN,
  output logic [2:0]          M_AXI_ARSIZE,
  output logic [1:0]          M_AXI_ARBURST,
  input  logic [31:0]         M_AXI_RDATA,
  input  logic [1:0]          M_AXI_RRESP,
  input  logic                M_AXI_RVALID,
  output logic                M_AXI_RREADY,
  input  logic [ID_W-1:0]     M_AXI_RID,
  input  logic                M_AXI_RLAST,
  output logic [N_REQ*3-1:0]  outstanding,
  output logic                rid_error
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [2:0]       cnt_q [N_REQ];
  logic [2:0]       cnt_d [N_REQ];
  logic [N_REQ-1:0] elig, gnt, rid_hit, dec;
  logic [PW-1:0]    gidx, ptr_q, ptr_d;
  logic             slot_free, any_gnt, rid_ok;
  logic             arvalid_q, arvalid_d, rid_error_q, rid_error_d;
  logic [ID_W-1:0]  arid_q, arid_d;
  ar_req_t          ar_q, ar_d;

  assign slot_free = !arvalid_q || M_AXI_ARREADY;
  assign any_gnt   = |gnt;

  // A requester only owns a beat while it has a burst in flight.
  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      elig[i]    = req_valid[i] && (cnt_q[i] < 3'(MAX_OUTSTANDING));
      rid_hit[i] = (M_AXI_RID == ID_W'(i)) && (cnt_q[i] != 3'd0);
      outstanding[3*i +: 3] = cnt_q[i];
    end
  end

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (elig),
    .ptr (ptr_q),
    .en  (slot_free),
    .gnt (gnt),
    .idx (gidx)
  );

  assign req_ready     = gnt;
  assign rid_ok        = |rid_hit;
  assign rsp_valid     = rid_hit & {N_REQ{M_AXI_RVALID}};
  assign M_AXI_RREADY  = rid_ok ? |(rid_hit & rsp_ready) : 1'b1;
  assign dec           = rid_hit & {N_REQ{M_AXI_RVALID & M_AXI_RREADY & M_AXI_RLAST}};
  assign rsp_data      = M_AXI_RDATA;
  assign rsp_resp      = M_AXI_RRESP;
  assign rsp_last      = M_AXI_RLAST;
  assign M_AXI_ARADDR  = ar_q.addr;
  assign M_AXI_ARLEN   = ar_q.len;
  assign M_AXI_ARID    = arid_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_ARSIZE  = AXI_SIZE_4B;
  assign M_AXI_ARBURST = AXI_BURST_INCR;
  assign rid_error     = rid_error_q;

  always_comb begin
    arvalid_d   = arvalid_q;
    ar_d        = ar_q;
    arid_d      = arid_q;
    ptr_d       = ptr_q;
    rid_error_d = rid_error_q | (M_AXI_RVALID & ~rid_ok);
    if (any_gnt) begin
      arvalid_d = 1'b1;
      ar_d.addr = req_addr[int'(gidx)*32 +: 32];
      ar_d.len  = req_len[int'(gidx)*8 +: 8];
      arid_d    = ID_W'(gidx);
      ptr_d     = (int'(gidx) == N_REQ - 1) ? '0 : gidx + PW'(1);
    end else if (arvalid_q && M_AXI_ARREADY) begin
      arvalid_d = 1'b0;
    end
    // Grant and final beat in the same cycle cancel out.
    for (int i = 0; i < N_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && !dec[i])      cnt_d[i] = cnt_q[i] + 3'd1;
      else if (!gnt[i] && dec[i]) cnt_d[i] = cnt_q[i] - 3'd1;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      arvalid_q   <= 1'b0;
      ar_q        <= '0;
      arid_q      <= '0;
      ptr_q       <= '0;
      rid_error_q <= 1'b0;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= '0;
    end else begin
      arvalid_q   <= arvalid_d;
      ar_q        <= ar_d;
      arid_q      <= arid_d;
      ptr_q       <= ptr_d;
      rid_error_q <= rid_error_d;
      for (int i = 0; i < N_REQ; i++) cnt_q[i] <= cnt_d[i];
    end
  end
endmodule
